mesm6_uart_v2: RTL and testbench

Parametrised second-generation MESM-6 UART peripheral on the 48-bit MESM-6 I/O bus (`i_addr`/`i_rd`/`i_wr`/`o_done`). Supersedes the fixed 8N1 UART with:
- configurable FIFO depth;
- 5–8 data bits, none/even/odd parity, 1 or 2 stop bits;
- 16× oversampled mid-bit receive;
- sticky parity/framing/overrun/drop error flags;
- a real maskable interrupt output.

---
 rtl/mesm6_uart_v2.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mesm6_uart_v2.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mesm6_uart_v2.sv
// MESM-6 I/O-bus UART: 5-8 data bits, optional parity, 1/2 stop bits, FIFOs and a maskable IRQ.
// TX and RX use separate dividers so every transmitted bit lasts exactly 16*(div+1) clocks.
module mesm6_uart_v2 #(
  parameter int unsigned FIFO_AW   = 5,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        interrupt,
  input  logic [14:0] i_addr,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [47:0] i_wdata,
  output logic [47:0] o_rdata,
  output logic        o_done,
  output logic        tx_pin,
  input  logic        rx_pin
);
  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam logic [FIFO_AW-1:0]   PtrInc = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DivInc = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic [25:0]          ctrl_q;
  logic [DIV_WIDTH-1:0] div;
  logic                 en, self_test, par_en, par_odd, stop2, rx_ie, tx_ie, err_ie;
  logic [2:0]           last_bit;
  logic [7:0]           data_mask;

  assign div       = ctrl_q[DIV_WIDTH-1:0];
  assign en        = ctrl_q[16];
  assign self_test = ctrl_q[17];
  assign last_bit  = {1'b0, ctrl_q[19:18]} + 3'd4;
  assign par_en    = ctrl_q[21];
  assign par_odd   = ctrl_q[20];
  assign stop2     = ctrl_q[22];
  assign rx_ie     = ctrl_q[23];
  assign tx_ie     = ctrl_q[24];
  assign err_ie    = ctrl_q[25];
  assign data_mask = 8'hff >> (3'd7 - last_bit);

  logic       rd_act, wr_act;
  logic [2:0] sel;
  logic       unused_bits;
  assign sel         = i_addr[2:0];
  // A strobe held across o_done acts only once.
  assign rd_act      = i_rd & ~o_done;
  assign wr_act      = i_wr & ~o_done;
  assign unused_bits = ^{i_addr[14:3], i_wdata[47:26], ctrl_q[15:0]};

  logic [7:0]         tx_mem [Depth];
  logic [7:0]         rx_mem [Depth];
  logic [FIFO_AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q, tx_cnt, rx_cnt;
  logic               tx_empty, tx_full, rx_empty, rx_full;
  logic               tx_push, tx_pop, rx_push, rx_pop, tx_drop_set;
  logic [7:0]         tx_head, rx_head;

  assign tx_cnt   = tx_wp_q - tx_rp_q;
  assign rx_cnt   = rx_wp_q - rx_rp_q;
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == '1);
  assign rx_full  = (rx_cnt == '1);
  assign tx_head  = tx_mem[tx_rp_q];
  assign rx_head  = rx_mem[rx_rp_q];

  tx_state_e            tx_state_q;
  logic [DIV_WIDTH-1:0] tx_div_q;
  logic [3:0]           tx_sub_q;
  logic [2:0]           tx_bit_q;
  logic [7:0]           tx_shift_q;
  logic                 tx_par_q, tx_tick, tx_bit_end;

  assign tx_tick     = (tx_div_q >= div);
  assign tx_bit_end  = tx_tick & (tx_sub_q == 4'hf);
  assign tx_pop      = en & (tx_state_q == TxIdle) & ~tx_empty;
  assign tx_push     = wr_act & (sel == 3'd0) & ~tx_full;
  assign tx_drop_set = wr_act & (sel == 3'd0) & tx_full;

  rx_state_e            rx_state_q;
  logic [1:0]           rx_sync_q;
  logic [DIV_WIDTH-1:0] rx_div_q;
  logic [3:0]           rx_sub_q;
  logic [2:0]           rx_bit_q;
  logic [7:0]           rx_data_q;
  logic                 rx_par_q, rx_s, rx_tick, rx_stop_smp, rx_par_err;

  assign rx_s        = rx_sync_q[1];
  assign rx_tick     = en & (rx_div_q >= div);
  assign rx_stop_smp = (rx_state_q == RxStop) & rx_tick & (rx_sub_q == 4'hf);
  assign rx_push     = rx_stop_smp & ~rx_full;
  assign rx_pop      = rd_act & (sel == 3'd0) & ~rx_empty;
  assign rx_par_err  = par_en & (rx_par_q != (^rx_data_q ^ par_odd));

  // err bits map to STATUS[8:5]: parity, frame, overrun, tx_drop.
  logic [3:0]  err_q, err_set, err_clr;
  logic [47:0] status, rdata;
  assign err_set = {tx_drop_set, rx_stop_smp & rx_full, rx_stop_smp & ~rx_s,
                    rx_stop_smp & rx_par_err};
  assign err_clr = (wr_act && sel == 3'd1) ? i_wdata[8:5] : 4'h0;

  always_comb begin
    status            = '0;
    status[0]         = tx_empty;
    status[1]         = tx_full;
    status[2]         = rx_empty;
    status[3]         = rx_full;
    status[4]         = (tx_state_q == TxIdle) & tx_empty;
    status[8:5]       = err_q;
    status[9 +: CntW] = {1'b0, rx_cnt};
  end

  always_comb begin
    rdata = '0;
    case (sel)
      3'd0:    rdata[8:0] = {rx_empty, rx_empty ? 8'h00 : rx_head};
      3'd1:    rdata = status;
      3'd7:    rdata[25:0] = ctrl_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= i_wdata[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q    <= 26'h00c0000;
      o_done    <= 1'b0;
      o_rdata   <= '0;
      err_q     <= '0;
      interrupt <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
    end else begin
      o_done <= i_rd | i_wr;
      if (rd_act) o_rdata <= rdata;
      if (wr_act) begin
        case (sel)
          3'd5:    ctrl_q <= ctrl_q & ~i_wdata[25:0];
          3'd6:    ctrl_q <= ctrl_q | i_wdata[25:0];
          3'd7:    ctrl_q <= i_wdata[25:0];
          default: ;
        endcase
      end
      // Set has priority over a simultaneous W1C.
      err_q <= (err_q & ~err_clr) | err_set;
      if (tx_push) tx_wp_q <= tx_wp_q + PtrInc;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PtrInc;
      if (rx_push) rx_wp_q <= rx_wp_q + PtrInc;
      if (rx_pop)  rx_rp_q <= rx_rp_q + PtrInc;
      interrupt <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | (err_ie & |err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      tx_pin     <= 1'b1;
      tx_div_q   <= '0;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else if (!en) begin
      tx_state_q <= TxIdle;
      tx_pin     <= 1'b1;
      tx_div_q   <= '0;
      tx_sub_q   <= '0;
    end else if (tx_state_q == TxIdle) begin
      tx_div_q <= '0;
      tx_sub_q <= '0;
      if (!tx_empty) begin
        tx_state_q <= TxStart;
        tx_pin     <= 1'b0;
        tx_shift_q <= tx_head & data_mask;
        tx_par_q   <= ^(tx_head & data_mask) ^ par_odd;
      end
    end else begin
      tx_div_q <= tx_tick ? '0 : tx_div_q + DivInc;
      if (tx_tick) tx_sub_q <= tx_sub_q + 4'd1;
      if (tx_bit_end) begin
        case (tx_state_q)
          TxStart: begin
            tx_state_q <= TxData;
            tx_pin     <= tx_shift_q[0];
            tx_bit_q   <= '0;
          end
          TxData: begin
            if (tx_bit_q == last_bit) begin
              tx_state_q <= par_en ? TxParity : TxStop1;
              tx_pin     <= par_en ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_pin     <= tx_shift_q[1];
            end
          end
          TxParity: begin
            tx_state_q <= TxStop1;
            tx_pin     <= 1'b1;
          end
          TxStop1: tx_state_q <= stop2 ? TxStop2 : TxIdle;
          default: tx_state_q <= TxIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      rx_div_q   <= '0;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], self_test ? tx_pin : rx_pin};
      if (!en) begin
        rx_state_q <= RxIdle;
        rx_div_q   <= '0;
        rx_sub_q   <= '0;
      end else begin
        rx_div_q <= rx_tick ? '0 : rx_div_q + DivInc;
        case (rx_state_q)
          RxIdle: begin
            if (rx_tick && !rx_s) begin
              rx_state_q <= RxStart;
              rx_sub_q   <= '0;
            end
          end
          RxStart: begin
            if (rx_tick) begin
              if (rx_sub_q == 4'd7) begin
                rx_sub_q   <= '0;
                rx_bit_q   <= '0;
                rx_data_q  <= '0;
                rx_state_q <= rx_s ? RxIdle : RxData;
              end else begin
                rx_sub_q <= rx_sub_q + 4'd1;
              end
            end
          end
          default: begin
            if (rx_tick) begin
              rx_sub_q <= rx_sub_q + 4'd1;
              if (rx_sub_q == 4'hf) begin
                case (rx_state_q)
                  RxData: begin
                    rx_data_q[rx_bit_q] <= rx_s;
                    if (rx_bit_q == last_bit) rx_state_q <= par_en ? RxParity : RxStop;
                    else rx_bit_q <= rx_bit_q + 3'd1;
                  end
                  RxParity: begin
                    rx_par_q   <= rx_s;
                    rx_state_q <= RxStop;
                  end
                  default: rx_state_q <= RxIdle;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mesm6_uart_v2.sv
// Directed bench for mesm6_uart_v2 (depth-4 FIFOs): registers, loopback framing, FIFO limits,
// error flags, interrupt and mid-frame disable.
module tb_mesm6_uart_v2;
  logic        clk = 1'b0;
  logic        reset_n, interrupt, i_rd, i_wr, o_done, tx_pin, rx_pin;
  logic [14:0] i_addr;
  logic [47:0] i_wdata, o_rdata;
  logic [47:0] rd;
  logic [10:0] seq;
  int          total = 0;
  int          bad = 0;

  mesm6_uart_v2 #(.FIFO_AW(2), .DIV_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .interrupt (interrupt),
    .i_addr    (i_addr),
    .i_rd      (i_rd),
    .i_wr      (i_wr),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_done    (o_done),
    .tx_pin    (tx_pin),
    .rx_pin    (rx_pin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [47:0] d);
    @(posedge clk); #1;
    i_addr  = {12'd0, a};
    i_wdata = d;
    i_wr    = 1'b1;
    @(posedge clk); #1;
    i_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, input int cycles, output logic [47:0] d);
    @(posedge clk); #1;
    i_addr = {12'd0, a};
    i_rd   = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    i_rd = 1'b0;
    d    = o_rdata;
  endtask

  // 8N1 frame at div=3 (64 clocks per bit); a bad stop bit is held low only briefly.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    idle(64);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(64);
    end
    rx_pin = stop_bit;
    idle(stop_bit ? 64 : 40);
    rx_pin = 1'b1;
    idle(64);
  endtask

  initial begin
    reset_n = 1'b0; i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0; rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_tx_pin", tx_pin, 1'b1);
    chk("rst_irq", interrupt, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_rdata", o_rdata, 48'h0);
    rd_reg(3'd7, 1, rd); chk("rst_ctrl", rd, 48'h00c0000);
    chk("rd_done", o_done, 1'b1);
    rd_reg(3'd1, 1, rd); chk("rst_status", rd, 48'h15);

    // 8N1 loopback, div 3.
    wr(3'd7, 48'h00f0003);
    rd_reg(3'd7, 1, rd); chk("ctrl_rb", rd, 48'h00f0003);
    wr(3'd0, 48'h5a);
    chk("pin_t1", tx_pin, 1'b1);
    idle(1);
    chk("pin_t2", tx_pin, 1'b0);
    idle(700);
    rd_reg(3'd0, 1, rd); chk("lb_data", rd, 48'h05a);
    rd_reg(3'd1, 1, rd); chk("lb_status", rd, 48'h15);

    // 7E2 loopback, bit-by-bit waveform.
    wr(3'd7, 48'h06b0003);
    wr(3'd0, 48'h41);
    idle(1);
    chk("e2_start", tx_pin, 1'b0);
    seq = 11'h682;
    for (int k = 0; k < 11; k++) begin
      idle(k == 0 ? 32 : 64);
      chk("e2_bit", tx_pin, seq[k]);
    end
    idle(100);
    rd_reg(3'd0, 1, rd); chk("e2_data", rd, 48'h041);
    rd_reg(3'd1, 1, rd); chk("e2_status", rd, 48'h15);

    // TX FIFO fill with en=0: 3 of 5 accepted.
    wr(3'd7, 48'h00c0003);
    for (int i = 1; i <= 5; i++) wr(3'd0, 48'(i));
    rd_reg(3'd1, 1, rd); chk("full_status", rd, 48'h106);
    wr(3'd1, 48'h100);
    rd_reg(3'd1, 1, rd); chk("w1c_status", rd, 48'h006);

    // Enable, then disable mid-frame while tx_pin is low.
    wr(3'd6, 48'h10000);
    idle(140);
    chk("mid_pin_low", tx_pin, 1'b0);
    wr(3'd5, 48'h10000);
    idle(1);
    chk("dis_pin_high", tx_pin, 1'b1);
    rd_reg(3'd7, 1, rd); chk("ctrlclr_rb", rd, 48'h00c0003);
    rd_reg(3'd1, 1, rd); chk("dis_status", rd, 48'h004);

    // Re-enable with loopback: remaining bytes 2 and 3 go out cleanly.
    wr(3'd6, 48'h30000);
    idle(1500);
    rd_reg(3'd0, 2, rd); chk("rd2_data", rd, 48'h002);
    rd_reg(3'd0, 1, rd); chk("rd_next", rd, 48'h003);
    rd_reg(3'd0, 1, rd); chk("rd_empty", rd[8], 1'b1);
    rd_reg(3'd1, 1, rd); chk("re_status", rd, 48'h15);

    // External RX: framing error with err_ie.
    wr(3'd7, 48'h20d0003);
    send_rx(8'h33, 1'b0);
    rd_reg(3'd1, 1, rd); chk("fe_status", rd, 48'h251);
    chk("fe_irq", interrupt, 1'b1);
    rd_reg(3'd0, 1, rd); chk("fe_data", rd, 48'h033);
    wr(3'd1, 48'h40);
    idle(3);
    chk("fe_irq_clr", interrupt, 1'b0);
    rd_reg(3'd1, 1, rd); chk("fe_clr_status", rd, 48'h15);

    // Overrun: 4 frames into a 3-entry RX FIFO.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    rd_reg(3'd1, 1, rd); chk("ovr_status", rd, 48'h699);
    chk("ovr_irq", interrupt, 1'b1);
    rd_reg(3'd0, 1, rd); chk("ovr_d0", rd, 48'h011);
    rd_reg(3'd0, 1, rd); chk("ovr_d1", rd, 48'h022);
    rd_reg(3'd0, 1, rd); chk("ovr_d2", rd, 48'h033);
    rd_reg(3'd0, 1, rd); chk("ovr_lost", rd[8], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
